// File: rtl/adc_arb_pkg.sv
// Shared types and defaults for the ADC arbiter: FSM state encoding,
// default parameter values and an index-width helper.
package adc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_N_CLIENTS = 2;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_TS_W      = 32;
  localparam int unsigned DEF_TIMEOUT   = 255;

  // Ceiling log2 with a floor of 1 so single-bit indices stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_arbiter_if.sv
// Client and ADC side signals of the ADC arbiter.
//   master : arbiter view (drives cli_rdy/cli_err/cli_dat/cli_ts/adc_req/busy)
//   slave  : environment view (drives cli_req/adc_rdy/adc_dat)
interface adc_arbiter_if
  import adc_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = DEF_N_CLIENTS,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TS_W      = DEF_TS_W
) ();

  logic [N_CLIENTS-1:0] cli_req;
  logic [N_CLIENTS-1:0] cli_rdy;
  logic [N_CLIENTS-1:0] cli_err;
  logic [DATA_W-1:0]    cli_dat;
  logic [TS_W-1:0]      cli_ts;
  logic                 adc_req;
  logic                 adc_rdy;
  logic [DATA_W-1:0]    adc_dat;
  logic                 busy;

  modport master (
    input  cli_req, adc_rdy, adc_dat,
    output cli_rdy, cli_err, cli_dat, cli_ts, adc_req, busy
  );

  modport slave (
    output cli_req, adc_rdy, adc_dat,
    input  cli_rdy, cli_err, cli_dat, cli_ts, adc_req, busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals asynchronous to clk.
//   clk, rst_n : clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronised output (two cycles of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one four-phase ADC between N_CLIENTS capture
// clients. Runs the req/rdy handshake for the granted client, returns the
// sample with a timestamp, and aborts via a watchdog if the ADC stalls.
//   clk, reset : clock, async active-low reset
//   bus        : client requests/results and ADC handshake (master modport)
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = DEF_N_CLIENTS,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TS_W      = DEF_TS_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  adc_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = clog2(N_CLIENTS);
  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned WD_W  = clog2(TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [TS_W-1:0]      ts_q;
  logic                 adc_req_q, adc_req_d;
  logic [N_CLIENTS-1:0] cli_rdy_q, cli_rdy_d;
  logic [N_CLIENTS-1:0] cli_err_q, cli_err_d;
  logic [DATA_W-1:0]    cli_dat_q, cli_dat_d;
  logic [TS_W-1:0]      cli_ts_q, cli_ts_d;
  logic                 busy_q, busy_d;

  logic                 rdy_s;
  logic                 found_c;
  logic [IDX_W-1:0]     win_c;
  logic [CW-1:0]        cand_c;
  logic [CW-1:0]        nxt_c;
  logic [N_CLIENTS-1:0] grant_oh_c;
  logic                 wd_exp_c;

  sync_2ff #(.WIDTH(1)) u_rdy_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (bus.adc_rdy),
    .q_o   (rdy_s)
  );

  // Round-robin search starting at rr_ptr, wrapping modulo N_CLIENTS.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cand_c = CW'(rr_ptr_q) + CW'(i);
      if (cand_c >= CW'(N_CLIENTS)) cand_c = cand_c - CW'(N_CLIENTS);
      if (!found_c && bus.cli_req[cand_c[IDX_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand_c[IDX_W-1:0];
      end
    end
  end

  // Pointer advances past the winner.
  always_comb begin
    nxt_c = CW'(win_c) + CW'(1);
    if (nxt_c >= CW'(N_CLIENTS)) nxt_c = '0;
  end

  assign grant_oh_c = N_CLIENTS'(1) << g_q;
  // wd_q counts completed cycles in the state; this is the TIMEOUT-th one.
  assign wd_exp_c   = (wd_q == WD_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = (state_q == IDLE) ? '0 : wd_q + WD_W'(1);
    adc_req_d = adc_req_q;
    cli_rdy_d = '0;
    cli_err_d = '0;
    cli_dat_d = cli_dat_q;
    cli_ts_d  = cli_ts_q;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          g_d       = win_c;
          rr_ptr_d  = nxt_c[IDX_W-1:0];
          adc_req_d = 1'b1;
          wd_d      = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        adc_req_d = 1'b1;
        if (rdy_s) begin
          cli_dat_d = bus.adc_dat;
          cli_ts_d  = ts_q;
          cli_rdy_d = grant_oh_c;
          adc_req_d = 1'b0;
          wd_d      = '0;
          state_d   = REL;
        end else if (wd_exp_c) begin
          cli_err_d = grant_oh_c;
          adc_req_d = 1'b0;
          wd_d      = '0;
          state_d   = ERR;
        end
      end
      REL: begin
        adc_req_d = 1'b0;
        if (!rdy_s) begin
          wd_d    = '0;
          state_d = IDLE;
        end else if (wd_exp_c) begin
          cli_err_d = grant_oh_c;
          wd_d      = '0;
          state_d   = IDLE;
        end
      end
      ERR: begin
        adc_req_d = 1'b0;
        if (!rdy_s || wd_exp_c) begin
          wd_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        adc_req_d = 1'b0;
        wd_d      = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      ts_q      <= '0;
      adc_req_q <= 1'b0;
      cli_rdy_q <= '0;
      cli_err_q <= '0;
      cli_dat_q <= '0;
      cli_ts_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      ts_q      <= ts_q + TS_W'(1);
      adc_req_q <= adc_req_d;
      cli_rdy_q <= cli_rdy_d;
      cli_err_q <= cli_err_d;
      cli_dat_q <= cli_dat_d;
      cli_ts_q  <= cli_ts_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.adc_req = adc_req_q;
  assign bus.cli_rdy = cli_rdy_q;
  assign bus.cli_err = cli_err_q;
  assign bus.cli_dat = cli_dat_q;
  assign bus.cli_ts  = cli_ts_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_adc_arbiter.sv
// Self-checking bench for adc_arbiter: an ADC model pushes each sample it
// returns onto a scoreboard queue; scenario tasks pop and compare.
module tb_adc_arbiter;

  logic clk;
  logic rst_n;

  adc_arbiter_if #(.N_CLIENTS(2), .DATA_W(8), .TS_W(4)) bus ();

  adc_arbiter #(
    .N_CLIENTS (2),
    .DATA_W    (8),
    .TS_W      (4),
    .TIMEOUT   (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] next_val;
  logic [7:0] last_dat;
  logic [3:0] last_ts;
  logic [3:0] ts_model;
  int         adc_mode;       // 0 normal, 1 never ready, 2 ready stuck high
  int         adc_delay;
  bit         release_stuck;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Reference free-running timestamp counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= 4'd0;
    else        ts_model <= ts_model + 4'd1;
  end

  // ADC model: four-phase responder, reset by the same net.
  initial begin
    bus.adc_rdy = 1'b0;
    bus.adc_dat = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.adc_req && !bus.adc_rdy && adc_mode != 1) begin
        repeat (adc_delay) begin @(posedge clk); #1; end
        if (rst_n && adc_mode != 1) begin
          bus.adc_dat = next_val;
          bus.adc_rdy = 1'b1;
          exp_q.push_back(next_val);
          next_val = next_val + 8'd1;
          if (adc_mode == 2) begin
            while (!release_stuck) begin @(posedge clk); #1; end
          end else begin
            while (bus.adc_req && rst_n) begin @(posedge clk); #1; end
          end
          bus.adc_rdy = 1'b0;
        end
      end
    end
  end

  // Waits for a cli_rdy pulse; returns observed outputs and scoreboard expectations.
  task automatic get_sample(input int budget, output logic [1:0] mask,
                            output logic [7:0] dat, output logic [3:0] ts,
                            output logic [7:0] exp_dat, output logic [3:0] exp_ts);
    mask = 2'b00; dat = 8'h00; ts = 4'h0; exp_dat = 8'hxx; exp_ts = 4'hx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.cli_rdy != 2'b00) begin
        mask   = bus.cli_rdy;
        dat    = bus.cli_dat;
        ts     = bus.cli_ts;
        exp_ts = ts_model - 4'd1;
        if (exp_q.size() > 0) exp_dat = exp_q.pop_front();
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.adc_req !== 1'b0) begin errors++; $display("FAIL reset_adc_req got %b want 0", bus.adc_req); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.cli_rdy !== 2'b00 || bus.cli_err !== 2'b00) begin errors++; $display("FAIL reset_pulses got rdy %b err %b want 00", bus.cli_rdy, bus.cli_err); end
    checks++; if (bus.cli_dat !== 8'h00 || bus.cli_ts !== 4'h0) begin errors++; $display("FAIL reset_data got dat %h ts %h want 0", bus.cli_dat, bus.cli_ts); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et; bit ok;
    adc_mode = 0; adc_delay = 3; next_val = 8'hA5;
    @(posedge clk); #1; bus.cli_req = 2'b01;
    get_sample(40, m, d, t, ed, et);
    bus.cli_req = 2'b00;
    checks++; if (m !== 2'b01) begin errors++; $display("FAIL single_mask got %b want 01", m); end
    checks++; if (d !== ed || d !== 8'hA5) begin errors++; $display("FAIL single_dat got %h want %h", d, ed); end
    checks++; if (t !== et) begin errors++; $display("FAIL single_ts got %h want %h", t, et); end
    checks++; if (bus.adc_req !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_release got req %b busy %b want 0 1", bus.adc_req, bus.busy); end
    wait_idle(20, ok);
    checks++; if (!ok || bus.adc_rdy !== 1'b0) begin errors++; $display("FAIL single_idle got ok %0d adc_rdy %b want 1 0", ok, bus.adc_rdy); end
    last_dat = d; last_ts = t;
  endtask

  task automatic test_contention();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et; bit ok;
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    rst_n = 1'b0; @(negedge clk); exp_q.delete(); rst_n = 1'b1;
    adc_mode = 0; adc_delay = 2; next_val = 8'h01;
    @(posedge clk); #1; bus.cli_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      get_sample(40, m, d, t, ed, et);
      if (i == 3) bus.cli_req = 2'b00;
      checks++; if (m !== want[i]) begin errors++; $display("FAIL contention_grant%0d got %b want %b", i, m, want[i]); end
      checks++; if (d !== ed || d !== 8'(i + 1)) begin errors++; $display("FAIL contention_dat%0d got %h want %h", i, d, 8'(i + 1)); end
      checks++; if (t !== et) begin errors++; $display("FAIL contention_ts%0d got %h want %h", i, t, et); end
      last_dat = d; last_ts = t;
    end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contention_idle got busy %b want 0", bus.busy); end
  endtask

  task automatic test_timeout();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et; bit ok;
    int hi_cnt, err_cnt; logic [1:0] err_mask; bit rdy_seen;
    adc_mode = 1;
    hi_cnt = 0; err_cnt = 0; err_mask = 2'b00; rdy_seen = 1'b0;
    @(posedge clk); #1; bus.cli_req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.adc_req) begin hi_cnt = 1; break; end
    end
    bus.cli_req = 2'b00;
    if (hi_cnt == 1) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.adc_req) hi_cnt++;
        else break;
      end
    end
    checks++; if (hi_cnt != 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", hi_cnt); end
    err_mask = bus.cli_err;
    for (int i = 0; i < 8; i++) begin
      if (bus.cli_err != 2'b00) err_cnt++;
      if (bus.cli_rdy != 2'b00) rdy_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (err_mask !== 2'b01) begin errors++; $display("FAIL timeout_err_mask got %b want 01", err_mask); end
    checks++; if (err_cnt != 1 || rdy_seen) begin errors++; $display("FAIL timeout_err_count got %0d rdy %0d want 1 0", err_cnt, rdy_seen); end
    checks++; if (bus.cli_dat !== last_dat || bus.cli_ts !== last_ts) begin errors++; $display("FAIL timeout_hold got %h/%h want %h/%h", bus.cli_dat, bus.cli_ts, last_dat, last_ts); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy %b want 0", bus.busy); end
    adc_mode = 0; adc_delay = 3; next_val = 8'h5A;
    @(posedge clk); #1; bus.cli_req = 2'b01;
    get_sample(40, m, d, t, ed, et);
    bus.cli_req = 2'b00;
    checks++; if (m !== 2'b01 || d !== ed) begin errors++; $display("FAIL timeout_recover got %b/%h want 01/%h", m, d, ed); end
    wait_idle(20, ok);
  endtask

  task automatic test_stuck_rdy();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et;
    int cnt;
    adc_mode = 2; adc_delay = 2; next_val = 8'h77; release_stuck = 1'b0;
    @(posedge clk); #1; bus.cli_req = 2'b10;
    get_sample(40, m, d, t, ed, et);
    bus.cli_req = 2'b00;
    checks++; if (m !== 2'b10 || d !== ed) begin errors++; $display("FAIL stuck_sample got %b/%h want 10/%h", m, d, ed); end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); cnt++;
      if (bus.cli_err != 2'b00) break;
    end
    checks++; if (bus.cli_err !== 2'b10 || cnt != 16) begin errors++; $display("FAIL stuck_err got %b after %0d want 10 after 16", bus.cli_err, cnt); end
    checks++; if (bus.busy !== 1'b0 || bus.adc_rdy !== 1'b1) begin errors++; $display("FAIL stuck_recover got busy %b rdy %b want 0 1", bus.busy, bus.adc_rdy); end
    release_stuck = 1'b1;
    repeat (3) @(negedge clk);
    release_stuck = 1'b0; adc_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et; bit ok, seen;
    adc_mode = 1; seen = 1'b0;
    @(posedge clk); #1; bus.cli_req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.adc_req) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midreset_req_rise got %b want 1", bus.adc_req); end
    repeat (2) @(posedge clk);
    #1; bus.cli_req = 2'b00; rst_n = 1'b0;
    #1;
    checks++; if (bus.adc_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_async got req %b busy %b want 0 0", bus.adc_req, bus.busy); end
    checks++; if (bus.cli_dat !== 8'h00 || bus.cli_ts !== 4'h0 || bus.cli_rdy !== 2'b00 || bus.cli_err !== 2'b00) begin errors++; $display("FAIL midreset_outputs got %h %h %b %b want 0", bus.cli_dat, bus.cli_ts, bus.cli_rdy, bus.cli_err); end
    repeat (2) @(negedge clk);
    exp_q.delete(); rst_n = 1'b1;
    adc_mode = 0; adc_delay = 3; next_val = 8'h3C;
    @(posedge clk); #1; bus.cli_req = 2'b11;
    get_sample(40, m, d, t, ed, et);
    bus.cli_req = 2'b00;
    checks++; if (m !== 2'b01 || d !== ed || d !== 8'h3C) begin errors++; $display("FAIL midreset_after got %b/%h want 01/3c", m, d); end
    checks++; if (t !== et) begin errors++; $display("FAIL midreset_ts got %h want %h", t, et); end
    wait_idle(20, ok);
  endtask

  task automatic test_ts_wrap();
    logic [1:0] m; logic [7:0] d, ed; logic [3:0] t, et, prev; bit ok, wrapped;
    adc_mode = 0; adc_delay = 1; next_val = 8'h10; wrapped = 1'b0; prev = 4'h0;
    @(posedge clk); #1; bus.cli_req = 2'b01;
    for (int i = 0; i < 6; i++) begin
      get_sample(40, m, d, t, ed, et);
      if (i == 5) bus.cli_req = 2'b00;
      checks++; if (m !== 2'b01 || d !== ed) begin errors++; $display("FAIL wrap_sample%0d got %b/%h want 01/%h", i, m, d, ed); end
      checks++; if (t !== et) begin errors++; $display("FAIL wrap_ts%0d got %h want %h", i, t, et); end
      if (i > 0 && t < prev) wrapped = 1'b1;
      prev = t;
    end
    wait_idle(20, ok);
    checks++; if (!wrapped) begin errors++; $display("FAIL wrap_seen got %0d want 1", wrapped); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missed got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cli_req = 2'b00;
    adc_mode = 0; adc_delay = 3; release_stuck = 1'b0; next_val = 8'h00;
    last_dat = 8'h00; last_ts = 4'h0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_stuck_rdy();
    test_reset_mid_req();
    test_ts_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_arbiter.md
Name: adc_arbiter

Overview:
- Shares the single asynchronous ADC (four-phase req/rdy/dat handshake) between N_CLIENTS capture clients, e.g. the TSC plus a monitor/calibration reader.
- Grants the ADC round-robin and runs the full four-phase handshake on the winner's behalf.
- Returns each sample with a 32-bit capture timestamp.
- Has a watchdog so a stalled ADC cannot hang the capture path.

Parameters:
- N_CLIENTS, 2, number of requesters (2..8).
- DATA_W, 8, ADC sample width.
- TS_W, 32, timestamp counter width.
- TIMEOUT, 255, max cycles spent waiting for any single rdy edge before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cli_req  in  N_CLIENTS  level request per client; held high = wants a sample.
- cli_rdy  out  N_CLIENTS  one-cycle pulse: sample for client i valid on cli_dat/cli_ts.
- cli_err  out  N_CLIENTS  one-cycle pulse: client i's conversion timed out.
- cli_dat  out  DATA_W  last captured sample (shared bus).
- cli_ts  out  TS_W  timestamp of last capture.
- adc_req  out  1  ADC request (to ADC req).
- adc_rdy  in  1  ADC ready, asynchronous to clk.
- adc_dat  in  DATA_W  ADC data; stable while adc_rdy high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, async): state=IDLE, adc_req=0, cli_rdy=0, cli_err=0, cli_dat=0, cli_ts=0, busy=0, rr_ptr=0, ts_cnt=0, wd_cnt=0, synchroniser flops=0.
- Synchroniser: adc_rdy passes through two flops to give rdy_s. adc_dat is sampled only when rdy_s=1.
- ts_cnt: free-running TS_W counter, +1 every cycle, wraps 2^TS_W-1 -> 0.
- Round-robin: search starts at rr_ptr and wraps modulo N_CLIENTS. The first client with cli_req=1 wins and is registered as g. On grant, rr_ptr <= (g+1) mod N_CLIENTS.
- IDLE: if any cli_req=1, register g, set adc_req<=1, wd_cnt<=0 -> REQ. busy rises on the same edge. Latency is req high at edge k to adc_req high after edge k+1.
- REQ: adc_req=1; wait for rdy_s=1.
  - On rdy_s=1: cli_dat<=adc_dat, cli_ts<=ts_cnt, cli_rdy[g]<=1 for exactly one cycle, adc_req<=0, wd_cnt<=0 -> REL.
  - If wd_cnt reaches TIMEOUT: adc_req<=0, cli_err[g]<=1 for one cycle, wd_cnt<=0 -> ERR.
- REL: wait for rdy_s=0 (four-phase return to zero), then -> IDLE.
  - Timeout in REL: cli_err[g] pulse, then -> IDLE.
- ERR: adc_req=0. When rdy_s=0 or wd_cnt reaches TIMEOUT -> IDLE. No data is delivered.
- A client holding cli_req across its cli_rdy pulse re-enters arbitration. Because rr_ptr has advanced, another requesting client wins first.
- A client dropping cli_req after grant does not abort the conversion; the cycle completes and cli_rdy still pulses.
- cli_dat/cli_ts hold their value until the next capture; a timeout does not change them.
- The minimum handshake is about 7 cycles: grant, 2 sync cycles for rise, 2 sync cycles for fall, plus ADC delay.
- Reset asserted mid-handshake: everything returns to reset values immediately and adc_req drops. The ADC is also reset by the same net.
- The watchdog counts every cycle spent in REQ, REL or ERR, and reloads to 0 on each state change.

Decomposition:
- Package adc_arb_pkg:
  - state enum {IDLE, REQ, REL, ERR}
  - default DATA_W/TS_W/TIMEOUT constants
  - client-index width function clog2(N_CLIENTS)
- Sub-module sync_2ff (parameterised width, async active-low reset) synchronises adc_rdy.
- The arbiter, FSM, watchdog and timestamp counter stay in adc_arbiter.

Test Plan:
- Single client: cli_req[0]=1 and an ADC model returning 8'hA5 with a 3-cycle delay -> one cli_rdy[0] pulse, cli_dat=8'hA5, cli_ts = ts_cnt at capture; adc_req then falls; busy returns to 0 after rdy falls.
- Contention: cli_req=2'b11 held for 4 samples -> grant order 0,1,0,1. cli_rdy never pulses for both clients in the same cycle; data values follow the ADC sequence 01,02,03,04.
- Timeout: ADC model never raises rdy, TIMEOUT=16 -> adc_req stays high for 16 cycles then drops; cli_err[g] pulses once; cli_dat is unchanged; the FSM reaches IDLE and the next request succeeds.
- Stuck-high rdy after capture: rdy held high -> REL times out, cli_err pulses, the FSM recovers to IDLE.
- Reset mid-REQ: reset low 2 cycles after adc_req rises -> all outputs are 0 immediately (async); after release a new cli_req completes normally with rr_ptr=0.
- Timestamp wrap: TS_W=4, continuous requests -> cli_ts wraps 15->0 with no missed cli_rdy pulses.
